rx_cmd_ctrl: RTL

RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

---
 rtl/rx_cmd_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl
// Decodes the byte stream from a UART receiver into register-file and ALU
// commands.
//   0xAA addr data      : register write
//   0xBB addr           : register read, issued once tx_ready is high
//   0xCC opA opB fun    : write opA to reg 0, opB to reg 1, then run ALU fun
//   0xDD fun            : run ALU fun on the current registers
// A frame is aborted (frm_err) on a receive error or when bytes stop arriving.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   rx_data/valid/err     : byte, one-cycle valid pulse, parity/stop error
//   tx_ready              : response path free; gates read and ALU issue
//   RF_WrEn/RdEn          : register-file write/read strobes (one cycle)
//   RF_Address/RF_WrData  : register-file address / write data (held)
//   ALU_EN/ALU_FUN        : ALU start strobe / function code (held)
//   CLK_GATE_EN           : ALU clock-gate enable
//   bad_cmd/frm_err/ovr_err : one-cycle error pulses
// -----------------------------------------------------------------------------
module rx_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       tx_ready,
  output logic       RF_WrEn,
  output logic       RF_RdEn,
  output logic [3:0] RF_Address,
  output logic [7:0] RF_WrData,
  output logic       ALU_EN,
  output logic [3:0] ALU_FUN,
  output logic       CLK_GATE_EN,
  output logic       bad_cmd,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, OP_A, OP_B, FUN, ALU_ISSUE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       addr_q;

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every branch reads the pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      bad_cmd     <= 1'b0;
      frm_err     <= 1'b0;
      ovr_err     <= 1'b0;
    end else begin
      // Strobes are single-cycle; the timeout counter restarts on every
      // state change or received byte unless explicitly advanced below.
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      ALU_EN  <= 1'b0;
      bad_cmd <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      cnt_q   <= '0;

      case (state_q)
        IDLE: begin
          CLK_GATE_EN <= 1'b0;
          // Errored bytes are dropped silently between frames.
          if (rx_valid && !rx_err) begin
            case (rx_data)
              8'hAA:   state_q <= WR_ADDR;
              8'hBB:   state_q <= RD_ADDR;
              8'hCC:   state_q <= OP_A;
              8'hDD:   state_q <= FUN;
              default: bad_cmd <= 1'b1;
            endcase
          end
        end

        RD_ISSUE: begin
          if (rx_valid) ovr_err <= 1'b1;
          if (tx_ready) begin
            RF_RdEn    <= 1'b1;
            RF_Address <= addr_q;
            state_q    <= IDLE;
          end
        end

        ALU_ISSUE: begin
          if (rx_valid) ovr_err <= 1'b1;
          // Gate stays open through the ALU_EN cycle itself.
          CLK_GATE_EN <= 1'b1;
          if (tx_ready) begin
            ALU_EN  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          // Receive states: expecting the next byte of a frame.
          if (rx_valid && rx_err) begin
            frm_err <= 1'b1;
            state_q <= IDLE;
          end else if (rx_valid) begin
            case (state_q)
              WR_ADDR: begin
                addr_q  <= rx_data[3:0];
                state_q <= WR_DATA;
              end
              WR_DATA: begin
                RF_WrEn    <= 1'b1;
                RF_Address <= addr_q;
                RF_WrData  <= rx_data;
                state_q    <= IDLE;
              end
              RD_ADDR: begin
                addr_q  <= rx_data[3:0];
                state_q <= RD_ISSUE;
              end
              OP_A: begin
                RF_WrEn    <= 1'b1;
                RF_Address <= 4'h0;
                RF_WrData  <= rx_data;
                state_q    <= OP_B;
              end
              OP_B: begin
                RF_WrEn    <= 1'b1;
                RF_Address <= 4'h1;
                RF_WrData  <= rx_data;
                state_q    <= FUN;
              end
              FUN: begin
                ALU_FUN     <= rx_data[3:0];
                CLK_GATE_EN <= 1'b1;
                state_q     <= ALU_ISSUE;
              end
              default: state_q <= IDLE;
            endcase
          end else if (cnt_q == CNT_LAST) begin
            // A byte arriving on the terminal cycle is taken by the branch
            // above, so the abort only fires on a genuinely silent line.
            frm_err <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
